// File: rtl/ime_log2_adapt_mc.sv
// rtl/ime_log2_adapt_mc.sv - multi-lane two-stage Mitchell log2 with epsilon floor, gated PWL correction, sticky poison
module ime_log2_adapt_mc #(
    parameter int N_CH   = 4,
    parameter int W_P    = 16,
    parameter int F_FRAC = 8,
    localparam int W_LOG = $clog2(W_P) + F_FRAC
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_CH*W_P-1:0]     in_prob_p,
    input  logic [N_CH*W_P-1:0]     in_prob_q,
    input  logic [7:0]              in_tuser,
    input  logic                    in_last,
    input  logic                    in_poison,
    input  logic                    pwl_en,
    input  logic [W_P-1:0]          delta_thresh,
    input  logic [W_P-1:0]          epsilon_q,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N_CH*W_LOG-1:0]   out_log_p,
    output logic [N_CH*W_LOG-1:0]   out_log_q,
    output logic [N_CH*W_P-1:0]     out_prob_p,
    output logic [N_CH*W_P-1:0]     out_prob_q,
    output logic [N_CH-1:0]         out_use_pwl,
    output logic [N_CH-1:0]         out_zero_p,
    output logic [7:0]              out_tuser,
    output logic                    out_last,
    output logic                    out_poison,
    output logic [15:0]             stat_pwl_cnt,
    input  logic                    stat_clr
);
    localparam int LW = $clog2(W_P);
    localparam logic [LW-1:0] TOP = LW'(W_P - 1);

    function automatic logic [LW-1:0] f_msb(input logic [W_P-1:0] x);
        logic [LW-1:0] r;
        r = '0;
        for (int i = 0; i < W_P; i++) if (x[i]) r = LW'(i);
        return r;
    endfunction

    function automatic logic [F_FRAC-1:0] f_mant(input logic [W_P-1:0] x, input logic [LW-1:0] msb);
        logic [W_P-1:0] sh;
        sh = x << (TOP - msb);
        return sh[W_P-2 -: F_FRAC];
    endfunction

    // t = m*(1-m) in fraction units; the weighted sum of its shifts stays below 2^F_FRAC - m
    function automatic logic [F_FRAC-1:0] f_corr(input logic [F_FRAC-1:0] m);
        logic [F_FRAC:0]   cm;
        logic [2*F_FRAC:0] prod;
        logic [F_FRAC-1:0] t;
        cm   = {1'b1, {F_FRAC{1'b0}}} - {1'b0, m};
        prod = {{(F_FRAC+1){1'b0}}, m} * {{F_FRAC{1'b0}}, cm};
        t    = prod[2*F_FRAC-1:F_FRAC];
        return (t >> 2) + (t >> 4) + (t >> 5);
    endfunction

    logic s1_valid_q, s2_valid_q, poison_q, poison_d;
    logic s1_ready, s2_ready;

    logic [N_CH*W_P-1:0]    s1_p_q, s1_qf_q, s1_qf_d;
    logic [N_CH*LW-1:0]     s1_msb_p_q, s1_msb_p_d, s1_msb_q_q, s1_msb_q_d;
    logic [N_CH*F_FRAC-1:0] s1_m_p_q, s1_m_p_d, s1_m_q_q, s1_m_q_d;
    logic [N_CH-1:0]        s1_pwl_q, s1_pwl_d, s1_zero_q, s1_zero_d;
    logic [7:0]             s1_tuser_q;
    logic                   s1_last_q, s1_poison_q;

    logic [N_CH*W_LOG-1:0]  log_p_q, log_p_d, log_q_q, log_q_d;
    logic [N_CH*W_P-1:0]    prob_p_q, prob_q_q;
    logic [N_CH-1:0]        use_pwl_q, zero_p_q;
    logic [7:0]             tuser_q;
    logic                   last_q, opoison_q;
    logic [15:0]            stat_q, stat_d;

    logic [W_P-1:0]    lp, lq, lqf;
    logic [W_P:0]      delta;
    logic [F_FRAC-1:0] mp, mq;
    logic [16:0]       pop, sum;

    assign s2_ready = !s2_valid_q || out_ready;
    assign s1_ready = !s1_valid_q || s2_ready;
    assign in_ready = s1_ready;

    always_comb begin
        s1_qf_d = '0; s1_msb_p_d = '0; s1_msb_q_d = '0;
        s1_m_p_d = '0; s1_m_q_d = '0; s1_pwl_d = '0; s1_zero_d = '0;
        lp = '0; lq = '0; lqf = '0; delta = '0;
        for (int i = 0; i < N_CH; i++) begin
            lp    = in_prob_p[i*W_P +: W_P];
            lq    = in_prob_q[i*W_P +: W_P];
            lqf   = (lq < epsilon_q) ? epsilon_q : lq;
            delta = (lp >= lqf) ? ({1'b0, lp} - {1'b0, lqf}) : ({1'b0, lqf} - {1'b0, lp});
            s1_qf_d[i*W_P +: W_P]          = lqf;
            s1_pwl_d[i]                    = pwl_en && (delta > {1'b0, delta_thresh});
            s1_zero_d[i]                   = (lp == '0);
            s1_msb_p_d[i*LW +: LW]         = f_msb(lp);
            s1_msb_q_d[i*LW +: LW]         = f_msb(lqf);
            s1_m_p_d[i*F_FRAC +: F_FRAC]   = f_mant(lp, f_msb(lp));
            s1_m_q_d[i*F_FRAC +: F_FRAC]   = f_mant(lqf, f_msb(lqf));
        end
    end

    always_comb begin
        log_p_d = '0; log_q_d = '0; mp = '0; mq = '0;
        for (int i = 0; i < N_CH; i++) begin
            mp = s1_m_p_q[i*F_FRAC +: F_FRAC];
            mq = s1_m_q_q[i*F_FRAC +: F_FRAC];
            if (s1_pwl_q[i]) begin
                mp = mp + f_corr(mp);
                mq = mq + f_corr(mq);
            end
            log_p_d[i*W_LOG +: W_LOG] = {s1_msb_p_q[i*LW +: LW], mp};
            log_q_d[i*W_LOG +: W_LOG] = {s1_msb_q_q[i*LW +: LW], mq};
        end
    end

    // Sticky poison covers the poisoned beat through the next accepted last beat
    always_comb begin
        poison_d = poison_q;
        if (in_valid && s1_ready) poison_d = in_last ? 1'b0 : (poison_q | in_poison);
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < N_CH; i++) pop = pop + 17'(use_pwl_q[i]);
        sum    = {1'b0, stat_q} + pop;
        stat_d = stat_q;
        if (stat_clr)                    stat_d = '0;
        else if (s2_valid_q && out_ready) stat_d = sum[16] ? 16'hFFFF : sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0; s2_valid_q <= 1'b0; poison_q <= 1'b0; stat_q <= '0;
            s1_p_q <= '0; s1_qf_q <= '0; s1_msb_p_q <= '0; s1_msb_q_q <= '0;
            s1_m_p_q <= '0; s1_m_q_q <= '0; s1_pwl_q <= '0; s1_zero_q <= '0;
            s1_tuser_q <= '0; s1_last_q <= 1'b0; s1_poison_q <= 1'b0;
            log_p_q <= '0; log_q_q <= '0; prob_p_q <= '0; prob_q_q <= '0;
            use_pwl_q <= '0; zero_p_q <= '0; tuser_q <= '0; last_q <= 1'b0; opoison_q <= 1'b0;
        end else begin
            poison_q <= poison_d;
            stat_q   <= stat_d;
            if (s1_ready) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_p_q      <= in_prob_p;   s1_qf_q    <= s1_qf_d;
                    s1_msb_p_q  <= s1_msb_p_d;  s1_msb_q_q <= s1_msb_q_d;
                    s1_m_p_q    <= s1_m_p_d;    s1_m_q_q   <= s1_m_q_d;
                    s1_pwl_q    <= s1_pwl_d;    s1_zero_q  <= s1_zero_d;
                    s1_tuser_q  <= in_tuser;    s1_last_q  <= in_last;
                    s1_poison_q <= poison_q | in_poison;
                end
            end
            if (s2_ready) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    log_p_q   <= log_p_d;    log_q_q  <= log_q_d;
                    prob_p_q  <= s1_p_q;     prob_q_q <= s1_qf_q;
                    use_pwl_q <= s1_pwl_q;   zero_p_q <= s1_zero_q;
                    tuser_q   <= s1_tuser_q; last_q   <= s1_last_q;
                    opoison_q <= s1_poison_q;
                end
            end
        end
    end

    assign out_valid    = s2_valid_q;
    assign out_log_p    = log_p_q;
    assign out_log_q    = log_q_q;
    assign out_prob_p   = prob_p_q;
    assign out_prob_q   = prob_q_q;
    assign out_use_pwl  = use_pwl_q;
    assign out_zero_p   = zero_p_q;
    assign out_tuser    = tuser_q;
    assign out_last     = last_q;
    assign out_poison   = opoison_q;
    assign stat_pwl_cnt = stat_q;
endmodule

// File: doc/ime_log2_adapt_mc.md
# ime_log2_adapt_mc

Multi-lane, two-stage pipelined successor of the adaptive log2 stage. Per beat, it floors N_CH probability pairs against epsilon and computes a fixed-point log2 with F_FRAC fractional bits (Mitchell mantissa estimate). Where the per-lane |p−q| exceeds the Δ threshold, it adds a piecewise-linear correction. Sits between the stream ingress and the core divergence operators, and carries packet-sticky poison and a PWL-usage statistic.

## Interface
- N_CH, 4: lanes per beat (≥1).
- W_P, 16: probability width per lane (≥2).
- F_FRAC, 8: fractional log bits (1..W_P-1).
- W_LOG (localparam), $clog2(W_P)+F_FRAC: log output width per lane.
- clk  in  1  single clock.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid / in_ready  in / out  1  ingress handshake.
- in_prob_p, in_prob_q  in  N_CH*W_P  lane i at [i*W_P +: W_P].
- in_tuser  in  8  sideband, passed through unchanged.
- in_last  in  1  end-of-packet.
- in_poison  in  1  beat poison.
- pwl_en  in  1  global PWL enable.
- delta_thresh  in  W_P  Δ gate threshold.
- epsilon_q  in  W_P  q floor.
- out_valid / out_ready  out / in  1  egress handshake.
- out_log_p, out_log_q  out  N_CH*W_LOG  {int, frac} log2 per lane.
- out_prob_p, out_prob_q  out  N_CH*W_P  p, and floored q.
- out_use_pwl  out  N_CH  per-lane correction applied.
- out_zero_p  out  N_CH  lane p was 0.
- out_tuser / out_last / out_poison  out  8/1/1  sideband.
- stat_pwl_cnt  out  16  saturating count of lane-corrections.
- stat_clr  in  1  synchronous clear of stat_pwl_cnt.

## Operation
- S1, on accept: per lane, qf = (q < epsilon_q) ? epsilon_q : q.
- S1 delta: Δ = |p − qf|, computed at W_P+1 bits.
- S1 gate: use_pwl = pwl_en && (Δ > delta_thresh); strict greater-than, so equality means no PWL.
- S1 normalize: msb = index of the highest set bit. Normalized mantissa m = F_FRAC bits immediately below the MSB after a left shift by (W_P−1−msb), zero-padded on the right.
- S1 sampling: config is sampled on the S1 accept cycle only.
- S2 log: log = {msb[W_LOG−F_FRAC−1:0], m'}.
- S2 correction: m' = m + corr when use_pwl, else m' = m.
- S2 corr: t = (m·(2^F_FRAC − m)) >> F_FRAC; corr = (t>>2)+(t>>4)+(t>>5). The sum cannot overflow F_FRAC bits.
- Zero input: value 0 gives log=0, m=0, and out_zero_p=1 for a zero p lane. qf is never 0 unless epsilon_q=0.
- Poison: sticky flag set when a beat with in_poison is accepted. That beat and every later beat up to and including the next accepted in_last beat emit out_poison=1. The flag clears after the last beat is accepted; a poison+last beat clears it immediately after.
- stat_pwl_cnt: adds popcount(use_pwl) when a beat leaves S2 (out_valid && out_ready), saturating at 0xFFFF.
- stat_clr priority: stat_clr wins over a same-cycle increment.

## Timing
- Latency: a beat accepted at cycle n is presented at n+2 when not stalled. Throughput is 1 beat/cycle.
- Ready chain, S2: s2_ready = !s2_valid || out_ready.
- Ready chain, S1: s1_ready = !s1_valid || s2_ready; in_ready = s1_ready.
- No combinational in_valid→out_valid path.
- Stall: while out_valid && !out_ready, all out_* hold stable.
- Stall propagation: a stall propagates to in_ready in the same cycle once S1 is also full.
- Depth: maximum two beats in flight, no drops.
- Reset, handshake/sideband: while rst_n=0 at a clk edge, S1/S2 valids, the sticky poison flag and stat_pwl_cnt clear. Every out_* reads 0.
- Reset, ready: in_ready=1 from the first cycle after reset.
- Reset mid-packet: in-flight beats are discarded and sticky poison is cleared.

## Test plan
- Single lane, W_P=16, F_FRAC=8, pwl_en=0: p=0x8000, q=0x8000. Required: out_log_p=0x0F00 at n+2 and use_pwl=0.
- Correction vs. gate: p=0x0003, q=0xFFFF, delta_thresh=0x0100, pwl_en=1. Required: log_p=0x0196, use_pwl=1. Repeat with delta_thresh=0xFFFC (Δ=0xFFFC, equal): log_p=0x0180, use_pwl=0.
- Epsilon: q=0x0000, epsilon_q=0x0010. Required: out_prob_q=0x0010 and log_q=0x0400. p=0 gives out_zero_p=1 and log_p=0.
- Backpressure: out_ready random at 30% with 100 back-to-back beats on 4 lanes. Required: no loss, no duplication, in-order, outputs stable while stalled, in_ready low only when both stages are full.
- Poison: packet of 5 beats with in_poison on beat 2. Required: beats 2–5 have out_poison=1, and the next packet's beat 1 has out_poison=0.
- Stats/reset: 3 beats, each with all 4 lanes PWL. Required: stat_pwl_cnt=12. Preload to 0xFFFE plus one beat gives 0xFFFF. stat_clr gives 0. rst_n=0 mid-stall gives out_valid=0 the next cycle.
